// File: rtl/level_sensor_conditioner.sv
// rtl/level_sensor_conditioner.sv - synchronizes, debounces and plausibility-checks tank level switches
module level_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_s,
    input  logic raw_i,
    input  logic fault_clr,
    output logic s_out,
    output logic i_out,
    output logic valid,
    output logic fault
);

    localparam int DB_W         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FC_W         = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
    localparam int START_CYCLES = 2 + DEBOUNCE_CYCLES;
    localparam int ST_W         = $clog2(START_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FAULT_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(START_CYCLES);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Channel bit 1 is the upper switch (s), bit 0 the lower switch (i).
    logic [1:0]      raw_vec;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      db;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state_q;
    state_t          state_d;
    logic [ST_W-1:0] start_cnt;
    logic [ST_W-1:0] start_cnt_d;
    logic [FC_W-1:0] fault_cnt;
    logic [FC_W-1:0] fault_cnt_d;
    logic            implausible;

    assign raw_vec     = {raw_s, raw_i};
    assign implausible = db[1] & ~db[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            db        <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_a <= raw_vec;
            sync_b <= sync_a;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync_b[ch] == db[ch]) begin
                    db_cnt[ch] <= '0;
                end else if (db_cnt[ch] == DB_LAST) begin
                    db[ch]     <= sync_b[ch];
                    db_cnt[ch] <= '0;
                end else begin
                    db_cnt[ch] <= db_cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INIT;
            start_cnt <= '0;
            fault_cnt <= '0;
        end else begin
            state_q   <= state_d;
            start_cnt <= start_cnt_d;
            fault_cnt <= fault_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt;
        fault_cnt_d = '0;
        s_out       = 1'b0;
        i_out       = 1'b0;
        valid       = 1'b0;
        fault       = 1'b0;
        case (state_q)
            INIT: begin
                // Hold off until the synchronizers and debouncers have settled.
                if (start_cnt == ST_LAST) begin
                    state_d = RUN;
                end else begin
                    start_cnt_d = start_cnt + 1'b1;
                end
            end
            RUN: begin
                s_out = db[1];
                i_out = db[0];
                valid = 1'b1;
                if (implausible) begin
                    if (fault_cnt == FC_LAST) begin
                        state_d = FAULT;
                    end else begin
                        fault_cnt_d = fault_cnt + 1'b1;
                    end
                end
            end
            FAULT: begin
                // Report a full tank so the pump fsm stops the pumps.
                fault = 1'b1;
                s_out = 1'b1;
                i_out = 1'b1;
                if (fault_clr && !implausible) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule
